cnn_conv_engine: RTL
====================

Name: cnn_conv_engine

Overview:
Parametrised single-layer convolution engine; successor to the fixed 32x32x3 -> 30x30x8 layer-1 datapath.
- Loads its weights and biases over a valid/ready config port, then streams windows from an external pixel memory.
- Computes all OUT_CH outputs of one output pixel in parallel and emits each result over a valid/ready port with its coordinates.
- Adds runtime stride (1/2), optional ReLU, weight reuse across frames, saturation and output back-pressure.

Parameters:
IMG_H, 32, input image rows
IMG_W, 32, input image columns
K, 3, square kernel size
IN_CH, 3, input channels packed per pixel word
OUT_CH, 8, output channels (parallel MAC lanes)
DATA_W, 16, signed fixed-point sample width
FRAC, 8, fractional bits of DATA_W format
ADDR_W, 16, width of row/col address ports

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  begin frame; sampled only in IDLE
reuse_w  in  1  with start: skip weight/bias load if weights are valid
stride2  in  1  with start: stride 2 when 1, else stride 1; latched
relu_en  in  1  with start: clamp negative results to 0; latched
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after last result accepted
cfg_valid  in  1  config word valid
cfg_ready  out  1  high in LOAD_W/LOAD_B
cfg_data  in  IN_CH*DATA_W  weight word (IN_CH taps) or bias in [DATA_W-1:0]
pix_rd_en  out  1  pixel read strobe
pix_row  out  ADDR_W  pixel row address
pix_col  out  ADDR_W  pixel column address
pix_data  in  IN_CH*DATA_W  read data, valid exactly 1 cycle after pix_rd_en
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_row  out  ADDR_W  output row
out_col  out  ADDR_W  output column
out_data  out  OUT_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]

Behaviour:
- Reset: all outputs 0; state IDLE; weight/bias registers 0; w_valid flag 0.
- Output dims: OH=(IMG_H-K)/S+1, OW=(IMG_W-K)/S+1, S=1 or 2 (defaults: 30x30 or 15x15). Raster order, column fastest.
- IDLE: start -> LOAD_W, or -> RUN if reuse_w && w_valid. start while busy is ignored.
- LOAD_W: accepts OUT_CH*K*K words on cfg_valid&&cfg_ready, ordered oc, ky, kx; -> LOAD_B after last word.
- LOAD_B: accepts OUT_CH bias words; after the last, set w_valid and -> RUN.
- RUN: issues K*K consecutive reads, one per cycle, at (r*S+ky, c*S+kx), ky-major; pix_rd_en high each cycle. -> DRAIN after last tap.
- MAC: data returning at t+1 is multiplied per lane. Lane oc accumulates sum over ic of w[oc][ky][kx][ic]*pix[ic] into an accumulator of width 2*DATA_W+8. Accumulators are cleared on the first tap of each pixel.
- DRAIN: one cycle for the last tap's MAC, then -> OUT.
- Result per lane: (acc + (bias<<<FRAC)) >>> FRAC (arithmetic shift), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then ReLU if latched relu_en.
- OUT: out_valid held with stable data/coords until out_ready. On accept, advance c, wrapping to the next r. After the last pixel -> DONE, else -> RUN.
- Per-pixel minimum latency: K*K+2 cycles with out_ready tied high.
- DONE: done=1 for one cycle -> IDLE. Mode latches are held for the whole frame.
- Back-pressure: no reads are issued while in OUT; no results are lost or duplicated.
- cfg_valid outside LOAD states is ignored.
- Reset mid-frame: immediate return to IDLE, w_valid cleared, no done pulse.

Decomposition:
- Package cnn_pkg: state enum (IDLE, LOAD_W, LOAD_B, RUN, DRAIN, OUT, DONE), ACC_W function of DATA_W, saturate-and-shift function.
- One sub-module: cnn_mac_lane (one output channel: IN_CH multipliers, adder tree, accumulator, bias/shift/saturate/ReLU). Instantiated OUT_CH times by generate.

Test Plan:
- Reset then idle: busy=0, out_valid=0, cfg_ready=0, pix_rd_en=0. start with reuse_w=1 before any load still enters LOAD_W (cfg_ready=1).
- Defaults, stride 1: center-tap weights 0x0100 for ic0 only, zero bias, pix ic0 = row*32+col (Q8.8 raw) -> out_data lane = pixel at (r+1, c+1). 900 results, then done pulse.
- stride2=1 with reuse_w=1 after a load -> no cfg_ready, 225 results; last coords (14,14); last read address (30,30).
- All weights 0x7FFF and pixels 0x7FFF -> every lane saturates to 0x7FFF. Negate weights with relu_en=1 -> 0x0000; with relu_en=0 -> 0x8000.
- Random out_ready (30% high) -> result sequence and coordinates identical to the out_ready=1 run; out_data stable while out_valid && !out_ready.
- start pulsed during RUN ignored. rst asserted mid-frame -> outputs 0 next edge, no done. Subsequent reuse_w start reloads weights.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and arithmetic helpers for the convolution engine.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_B,
    RUN,
    DRAIN,
    OUT,
    DONE
  } state_e;

  function automatic int unsigned acc_w(input int unsigned data_w);
    return 2 * data_w + 8;
  endfunction

  // Adds the bias aligned to the accumulator's fraction, drops FRAC bits and
  // clamps to a signed dw-bit range; callers keep the low dw bits.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] acc,
    input logic signed [63:0] bias,
    input int unsigned        dw,
    input int unsigned        frac
  );
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = (acc + (bias <<< frac)) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = ~hi;
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/cnn_mac_lane.sv
// One output channel: per-tap dot product over input channels, accumulator,
// then bias, fixed-point shift, saturation and optional ReLU.
module cnn_mac_lane
  import cnn_pkg::*;
#(
  parameter int unsigned IN_CH  = 3,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mac_en_i,
  input  logic                    clr_i,
  input  logic                    relu_i,
  input  logic [IN_CH*DATA_W-1:0] w_i,
  input  logic [IN_CH*DATA_W-1:0] pix_i,
  input  logic [DATA_W-1:0]       bias_i,
  output logic [DATA_W-1:0]       res_o
);

  localparam int unsigned AW = acc_w(DATA_W);

  logic signed [AW-1:0]       acc_q;
  logic signed [AW-1:0]       acc_d;
  logic signed [AW-1:0]       tap_sum;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [63:0]         sat_v;
  logic                       unused_sat_hi;

  always_comb begin
    tap_sum = '0;
    prod    = '0;
    for (int unsigned i = 0; i < IN_CH; i++) begin
      prod    = (2*DATA_W)'($signed(w_i[i*DATA_W +: DATA_W]))
              * (2*DATA_W)'($signed(pix_i[i*DATA_W +: DATA_W]));
      tap_sum = tap_sum + AW'(prod);
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (mac_en_i) begin
      acc_d = (clr_i ? '0 : acc_q) + tap_sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    sat_v = sat_shift(64'(acc_q), 64'($signed(bias_i)), DATA_W, FRAC);
    res_o = sat_v[DATA_W-1:0];
    if (relu_i && sat_v[DATA_W-1]) begin
      res_o = '0;
    end
  end

  assign unused_sat_hi = ^sat_v[63:DATA_W];

endmodule

// File: rtl/cnn_conv_engine.sv
// Single-layer convolution engine: weight/bias load, windowed pixel reads,
// OUT_CH parallel MAC lanes and a back-pressured result port.
module cnn_conv_engine
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned K      = 3,
  parameter int unsigned IN_CH  = 3,
  parameter int unsigned OUT_CH = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     reuse_w,
  input  logic                     stride2,
  input  logic                     relu_en,
  output logic                     busy,
  output logic                     done,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [IN_CH*DATA_W-1:0]  cfg_data,
  output logic                     pix_rd_en,
  output logic [ADDR_W-1:0]        pix_row,
  output logic [ADDR_W-1:0]        pix_col,
  input  logic [IN_CH*DATA_W-1:0]  pix_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_row,
  output logic [ADDR_W-1:0]        out_col,
  output logic [OUT_CH*DATA_W-1:0] out_data
);

  localparam int unsigned KK     = K * K;
  localparam int unsigned TW     = (KK > 1) ? $clog2(KK) : 1;
  localparam int unsigned KW     = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned OCW    = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int unsigned WORD_W = IN_CH * DATA_W;

  localparam logic [TW-1:0]     TAP_LAST = TW'(KK - 1);
  localparam logic [KW-1:0]     K_LAST   = KW'(K - 1);
  localparam logic [OCW-1:0]    OC_LAST  = OCW'(OUT_CH - 1);
  localparam logic [ADDR_W-1:0] LAST_R1  = ADDR_W'(IMG_H - K);
  localparam logic [ADDR_W-1:0] LAST_C1  = ADDR_W'(IMG_W - K);
  localparam logic [ADDR_W-1:0] LAST_R2  = ADDR_W'((IMG_H - K) / 2);
  localparam logic [ADDR_W-1:0] LAST_C2  = ADDR_W'((IMG_W - K) / 2);

  state_e              state_q;
  state_e              state_d;
  logic                w_valid_q;
  logic                stride_q;
  logic                relu_q;
  logic [OCW-1:0]      ld_oc_q;
  logic [TW-1:0]       ld_tap_q;
  logic [TW-1:0]       tap_q;
  logic [TW-1:0]       mac_tap_q;
  logic                mac_en_q;
  logic [KW-1:0]       ky_q;
  logic [KW-1:0]       kx_q;
  logic [ADDR_W-1:0]   r_q;
  logic [ADDR_W-1:0]   c_q;
  logic [ADDR_W-1:0]   last_r;
  logic [ADDR_W-1:0]   last_c;
  logic                last_pix;
  logic [WORD_W-1:0]   w_q    [OUT_CH][KK];
  logic [DATA_W-1:0]   bias_q [OUT_CH];

  assign last_r   = stride_q ? LAST_R2 : LAST_R1;
  assign last_c   = stride_q ? LAST_C2 : LAST_C1;
  assign last_pix = (r_q == last_r) && (c_q == last_c);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = (reuse_w && w_valid_q) ? RUN : LOAD_W;
      LOAD_W: if (cfg_valid && ld_oc_q == OC_LAST && ld_tap_q == TAP_LAST) state_d = LOAD_B;
      LOAD_B: if (cfg_valid && ld_oc_q == OC_LAST) state_d = RUN;
      RUN:    if (tap_q == TAP_LAST) state_d = DRAIN;
      DRAIN:  state_d = OUT;
      OUT:    if (out_ready) state_d = last_pix ? DONE : RUN;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign cfg_ready = (state_q == LOAD_W) || (state_q == LOAD_B);
  assign pix_rd_en = (state_q == RUN);
  assign pix_row   = pix_rd_en ? ((r_q << stride_q) + ADDR_W'(ky_q)) : '0;
  assign pix_col   = pix_rd_en ? ((c_q << stride_q) + ADDR_W'(kx_q)) : '0;
  assign out_valid = (state_q == OUT);
  assign out_row   = r_q;
  assign out_col   = c_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned oc = 0; oc < OUT_CH; oc++) begin
        for (int unsigned t = 0; t < KK; t++) begin
          w_q[oc][t] <= '0;
        end
        bias_q[oc] <= '0;
      end
    end else if (cfg_valid) begin
      if (state_q == LOAD_W) w_q[ld_oc_q][ld_tap_q] <= cfg_data;
      if (state_q == LOAD_B) bias_q[ld_oc_q] <= cfg_data[DATA_W-1:0];
    end
  end

  // Load and tap counters wrap back to zero on their final step, so every
  // load and every pixel window starts from a clean count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      w_valid_q <= 1'b0;
      stride_q  <= 1'b0;
      relu_q    <= 1'b0;
      ld_oc_q   <= '0;
      ld_tap_q  <= '0;
      tap_q     <= '0;
      mac_tap_q <= '0;
      mac_en_q  <= 1'b0;
      ky_q      <= '0;
      kx_q      <= '0;
      r_q       <= '0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      mac_en_q  <= (state_q == RUN);
      mac_tap_q <= tap_q;
      case (state_q)
        IDLE: if (start) begin
          stride_q <= stride2;
          relu_q   <= relu_en;
          r_q      <= '0;
          c_q      <= '0;
        end
        LOAD_W: if (cfg_valid) begin
          if (ld_tap_q == TAP_LAST) begin
            ld_tap_q <= '0;
            ld_oc_q  <= (ld_oc_q == OC_LAST) ? '0 : ld_oc_q + 1'b1;
          end else begin
            ld_tap_q <= ld_tap_q + 1'b1;
          end
        end
        LOAD_B: if (cfg_valid) begin
          if (ld_oc_q == OC_LAST) begin
            ld_oc_q   <= '0;
            w_valid_q <= 1'b1;
          end else begin
            ld_oc_q <= ld_oc_q + 1'b1;
          end
        end
        RUN: begin
          tap_q <= (tap_q == TAP_LAST) ? '0 : tap_q + 1'b1;
          if (kx_q == K_LAST) begin
            kx_q <= '0;
            ky_q <= (ky_q == K_LAST) ? '0 : ky_q + 1'b1;
          end else begin
            kx_q <= kx_q + 1'b1;
          end
        end
        OUT: if (out_ready && !last_pix) begin
          if (c_q == last_c) begin
            c_q <= '0;
            r_q <= r_q + 1'b1;
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < OUT_CH; g++) begin : g_lane
    cnn_mac_lane #(
      .IN_CH  (IN_CH),
      .DATA_W (DATA_W),
      .FRAC   (FRAC)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .mac_en_i (mac_en_q),
      .clr_i    (mac_tap_q == '0),
      .relu_i   (relu_q),
      .w_i      (w_q[g][mac_tap_q]),
      .pix_i    (pix_data),
      .bias_i   (bias_q[g]),
      .res_o    (out_data[g*DATA_W +: DATA_W])
    );
  end

endmodule
